// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - FIX 4.2 message codes, tags and length constants shared by the composer
package fix_pkg;
   localparam logic [3:0] MSG_LOGON      = 4'h1;
   localparam logic [3:0] MSG_LOGOUT     = 4'h2;
   localparam logic [3:0] MSG_HEARTBEAT  = 4'h3;
   localparam logic [3:0] MSG_RESEND_REQ = 4'h4;

   localparam logic [7:0] SOH           = 8'h01;
   localparam logic [7:0] BODY_OVERHEAD = 8'd33;
   localparam logic [7:0] LOGON_EXTRA   = 8'd12;
   localparam logic [7:0] RESEND_EXTRA  = 8'd16;
   localparam logic [7:0] HDR_LEN       = 8'd16;  // "8=FIX.4.2|9=LLL|"
   localparam logic [7:0] TRAILER_LAST  = 8'd6;   // final SOH within "10=CCC|"

   localparam logic [71:0] TAG_BEGIN     = "8=FIX.4.2";
   localparam logic [15:0] TAG_BODYLEN   = "9=";
   localparam logic [23:0] TAG_MSG_TYPE  = "35=";
   localparam logic [23:0] TAG_SENDER    = "49=";
   localparam logic [23:0] TAG_TARGET    = "56=";
   localparam logic [23:0] TAG_SEQ       = "34=";
   localparam logic [15:0] TAG_BEGIN_SEQ = "7=";
   localparam logic [23:0] TAG_CHECKSUM  = "10=";
   localparam logic [95:0] LOGON_FIELDS  = {"98=0", SOH, "108=30", SOH};
   localparam logic [39:0] RESEND_TAIL   = {"16=0", SOH};

   typedef enum logic [1:0] {IDLE, CALC, EMIT, TRAIL} comp_state_t;

   function automatic logic is_msg_type(input logic [3:0] t);
      return (t == MSG_LOGON) || (t == MSG_LOGOUT) || (t == MSG_HEARTBEAT) || (t == MSG_RESEND_REQ);
   endfunction

   function automatic logic [7:0] type_char(input logic [3:0] t);
      case (t)
         MSG_LOGON:      return 8'h41;
         MSG_LOGOUT:     return 8'h35;
         MSG_RESEND_REQ: return 8'h32;
         default:        return 8'h30;
      endcase
   endfunction

   function automatic logic [7:0] extra_len(input logic [3:0] t);
      case (t)
         MSG_LOGON:      return LOGON_EXTRA;
         MSG_RESEND_REQ: return RESEND_EXTRA;
         default:        return 8'd0;
      endcase
   endfunction

   // Byte i of a left-aligned 16-byte string.
   function automatic logic [7:0] pick_byte(input logic [127:0] v, input logic [7:0] i);
      return 8'((v << {i, 3'b000}) >> 120);
   endfunction

   function automatic logic [7:0] bcd_char(input logic [31:0] v, input logic [7:0] k);
      return 8'h30 + 8'((v << {k, 2'b00}) >> 28);
   endfunction
endpackage

// File: rtl/fix_dec3.sv
// rtl/fix_dec3.sv - 8-bit binary to three zero-padded ASCII decimal digits
module fix_dec3 (
   input  logic [7:0]  bin,
   output logic [23:0] ascii
);
   logic [7:0] hund, tens, ones;

   always_comb begin
      hund  = bin / 8'd100;
      tens  = (bin / 8'd10) % 8'd10;
      ones  = bin % 8'd10;
      ascii = {8'h30 + hund, 8'h30 + tens, 8'h30 + ones};
   end
endmodule

// File: rtl/fix_msg_composer.sv
// rtl/fix_msg_composer.sv - serialises FIX 4.2 session messages byte-by-byte to the TOE
module fix_msg_composer
   import fix_pkg::*;
#(
   parameter int          NUM_HOST    = 4,
   parameter int          VALUE_WIDTH = 64,
   parameter int          SIZE        = 4,
   parameter logic [63:0] SENDER_ID   = "FIXENG01"
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   initiate_msg_i,
   input  logic [3:0]             create_message_i,
   input  logic [NUM_HOST-1:0]    host_i,
   input  logic [VALUE_WIDTH-1:0] targetCompId_i,
   input  logic [SIZE-1:0]        s_v_targetCompId_i,
   input  logic [31:0]            seq_bcd_i,
   input  logic [31:0]            begin_seq_bcd_i,
   input  logic                   tx_ready_i,
   output logic [7:0]             tx_data_o,
   output logic                   tx_valid_o,
   output logic                   tx_sop_o,
   output logic                   tx_eop_o,
   output logic [NUM_HOST-1:0]    tx_host_o,
   output logic                   busy_o,
   output logic                   seq_incr_o,
   output logic                   error_o
);
   comp_state_t            state;
   logic [3:0]             type_q;
   logic [NUM_HOST-1:0]    host_q;
   logic [VALUE_WIDTH-1:0] target_q;
   logic [SIZE-1:0]        n_q;
   logic [31:0]            seq_q, begin_q;
   logic [7:0]             body_len, cks, pos;
   logic [23:0]            len_ascii, cks_ascii;
   logic [7:0]             np, nb, n8, q, r, s, t;
   logic                   legal;

   fix_dec3 u_dec_len (.bin(body_len), .ascii(len_ascii));
   fix_dec3 u_dec_cks (.bin(cks),      .ascii(cks_ascii));

   assign legal = is_msg_type(create_message_i) && (s_v_targetCompId_i != '0)
                  && (32'(s_v_targetCompId_i) <= VALUE_WIDTH / 8);

   // Next byte to present, chosen by its offset within each field; q/r/s/t rebase np per region.
   always_comb begin
      np = pos + 8'd1;
      n8 = 8'(n_q);
      q  = np - HDR_LEN;
      r  = q - 8'd21 - n8;
      s  = r - 8'd12;
      t  = np - HDR_LEN - body_len;
      nb = SOH;
      if (np < HDR_LEN)          nb = pick_byte({TAG_BEGIN, SOH, TAG_BODYLEN, len_ascii, SOH}, np);
      else if (q < 8'd5)         nb = pick_byte({TAG_MSG_TYPE, type_char(type_q), SOH, 88'd0}, q);
      else if (q < 8'd8)         nb = pick_byte({TAG_SENDER, 104'd0}, q - 8'd5);
      else if (q < 8'd16)        nb = pick_byte({SENDER_ID, 64'd0}, q - 8'd8);
      else if (q == 8'd16)       nb = SOH;
      else if (q < 8'd20)        nb = pick_byte({TAG_TARGET, 104'd0}, q - 8'd17);
      else if (q < 8'd20 + n8)   nb = pick_byte(128'(target_q) << (128 - VALUE_WIDTH), q - 8'd20);
      else if (q == 8'd20 + n8)  nb = SOH;
      else if (r < 8'd3)         nb = pick_byte({TAG_SEQ, 104'd0}, r);
      else if (r < 8'd11)        nb = bcd_char(seq_q, r - 8'd3);
      else if (r == 8'd11)       nb = SOH;
      else if (np < HDR_LEN + body_len) begin
         if (type_q == MSG_LOGON) nb = pick_byte({LOGON_FIELDS, 32'd0}, s);
         else if (s < 8'd2)       nb = pick_byte({TAG_BEGIN_SEQ, 112'd0}, s);
         else if (s < 8'd10)      nb = bcd_char(begin_q, s - 8'd2);
         else if (s == 8'd10)     nb = SOH;
         else                     nb = pick_byte({RESEND_TAIL, 88'd0}, s - 8'd11);
      end
      else if (t < 8'd3)         nb = pick_byte({TAG_CHECKSUM, 104'd0}, t);
      else if (t < 8'd6)         nb = pick_byte({cks_ascii, 104'd0}, t - 8'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         type_q     <= '0;
         host_q     <= '0;
         target_q   <= '0;
         n_q        <= '0;
         seq_q      <= '0;
         begin_q    <= '0;
         body_len   <= '0;
         cks        <= '0;
         pos        <= '0;
         tx_data_o  <= '0;
         tx_valid_o <= 1'b0;
         tx_sop_o   <= 1'b0;
         tx_eop_o   <= 1'b0;
         tx_host_o  <= '0;
         busy_o     <= 1'b0;
         seq_incr_o <= 1'b0;
         error_o    <= 1'b0;
      end else begin
         seq_incr_o <= 1'b0;
         error_o    <= initiate_msg_i && ((state != IDLE) || !legal);
         case (state)
            IDLE: if (initiate_msg_i && legal) begin
               type_q   <= create_message_i;
               host_q   <= host_i;
               target_q <= targetCompId_i;
               n_q      <= s_v_targetCompId_i;
               seq_q    <= seq_bcd_i;
               begin_q  <= begin_seq_bcd_i;
               busy_o   <= 1'b1;
               state    <= CALC;
            end
            CALC: begin
               body_len   <= BODY_OVERHEAD + n8 + extra_len(type_q);
               cks        <= '0;
               pos        <= '0;
               tx_data_o  <= TAG_BEGIN[71:64];
               tx_valid_o <= 1'b1;
               tx_sop_o   <= 1'b1;
               tx_eop_o   <= 1'b0;
               tx_host_o  <= host_q;
               state      <= EMIT;
            end
            default: if (tx_ready_i) begin
               if (tx_eop_o) begin
                  tx_data_o  <= '0;
                  tx_valid_o <= 1'b0;
                  tx_eop_o   <= 1'b0;
                  busy_o     <= 1'b0;
                  seq_incr_o <= 1'b1;
                  state      <= IDLE;
               end else begin
                  pos       <= np;
                  tx_data_o <= nb;
                  tx_sop_o  <= 1'b0;
                  tx_eop_o  <= (np == HDR_LEN + body_len + TRAILER_LAST);
                  if (state == EMIT) begin
                     cks <= cks + tx_data_o;
                     if (np == HDR_LEN + body_len) state <= TRAIL;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fix_msg_composer.sv
// tb/tb_fix_msg_composer.sv - randomized self-checking bench for fix_msg_composer
module tb_fix_msg_composer;
   import fix_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, initiate_msg = 1'b0, tx_ready = 1'b1;
   logic [3:0]  create_message = '0, host = '0, s_v_target = '0;
   logic [63:0] target_id = '0;
   logic [31:0] seq_bcd = '0, begin_seq_bcd = '0;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_sop, tx_eop, busy, seq_incr, error;
   logic [3:0]  tx_host;

   always #5 clk = ~clk;

   fix_msg_composer dut (
      .clk(clk), .rst(rst), .initiate_msg_i(initiate_msg), .create_message_i(create_message),
      .host_i(host), .targetCompId_i(target_id), .s_v_targetCompId_i(s_v_target),
      .seq_bcd_i(seq_bcd), .begin_seq_bcd_i(begin_seq_bcd), .tx_ready_i(tx_ready),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_sop_o(tx_sop), .tx_eop_o(tx_eop),
      .tx_host_o(tx_host), .busy_o(busy), .seq_incr_o(seq_incr), .error_o(error)
   );

   int n_checks = 0, n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [7:0]  body_q[$], exp_q[$], got_q[$], ref_q[$];
   int          sop_q[$], eop_q[$];
   int          host_bad = 0, incr_cnt = 0, incr_busy_bad = 0, err_cnt = 0;
   logic [3:0]  cur_host = '0;
   bit          rand_ready = 1'b0, stall_prev = 1'b0;
   logic [13:0] prev_bus = '0;

   initial forever begin
      @(posedge clk);
      #1 tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check_eq("hold_while_stalled", 64'({tx_valid, tx_data, tx_sop, tx_eop, tx_host}),
                     64'({1'b1, prev_bus}));
         if (tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            if (tx_sop) sop_q.push_back(got_q.size() - 1);
            if (tx_eop) eop_q.push_back(got_q.size() - 1);
            if (tx_host != cur_host) host_bad++;
         end
         stall_prev = tx_valid && !tx_ready;
         prev_bus   = {tx_data, tx_sop, tx_eop, tx_host};
         if (seq_incr) begin
            incr_cnt++;
            if (busy) incr_busy_bad++;
         end
         if (error) err_cnt++;
      end
   end

   // Reference model: the message as the FIX rules describe it, built from text fields.
   task automatic add_body(input string s);
      for (int i = 0; i < s.len(); i++) body_q.push_back(s[i]);
   endtask

   task automatic add_exp(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic add_bcd(input logic [31:0] v);
      for (int i = 0; i < 8; i++) body_q.push_back(8'h30 + 8'(v[31-4*i -: 4]));
   endtask

   task automatic build_exp(input logic [3:0] typ, input string tgt, input logic [31:0] seq,
                            input logic [31:0] beg);
      string tc;
      int    sum;
      case (typ)
         MSG_LOGON:      tc = "A";
         MSG_LOGOUT:     tc = "5";
         MSG_RESEND_REQ: tc = "2";
         default:        tc = "0";
      endcase
      body_q.delete();
      add_body({"35=", tc}); body_q.push_back(8'h01);
      add_body("49=FIXENG01"); body_q.push_back(8'h01);
      add_body({"56=", tgt}); body_q.push_back(8'h01);
      add_body("34="); add_bcd(seq); body_q.push_back(8'h01);
      if (typ == MSG_LOGON) begin
         add_body("98=0"); body_q.push_back(8'h01);
         add_body("108=30"); body_q.push_back(8'h01);
      end else if (typ == MSG_RESEND_REQ) begin
         add_body("7="); add_bcd(beg); body_q.push_back(8'h01);
         add_body("16=0"); body_q.push_back(8'h01);
      end
      exp_q.delete();
      add_exp("8=FIX.4.2"); exp_q.push_back(8'h01);
      add_exp({"9=", $sformatf("%03d", body_q.size())}); exp_q.push_back(8'h01);
      foreach (body_q[i]) exp_q.push_back(body_q[i]);
      sum = 0;
      foreach (exp_q[i]) sum += int'(exp_q[i]);
      add_exp({"10=", $sformatf("%03d", sum % 256)}); exp_q.push_back(8'h01);
   endtask

   function automatic logic [23:0] lll_got();
      if (got_q.size() < 15) return '0;
      return {got_q[12], got_q[13], got_q[14]};
   endfunction

   task automatic drive_req(input logic [3:0] typ, input string tgt, input logic [3:0] n,
                            input logic [31:0] seq, input logic [31:0] beg, input logic [3:0] h);
      logic [63:0] tv;
      tv = {$urandom, $urandom};
      for (int i = 0; i < tgt.len() && i < 8; i++) tv[63-8*i -: 8] = tgt[i];
      create_message = typ; target_id = tv; s_v_target = n;
      seq_bcd = seq; begin_seq_bcd = beg; host = h;
   endtask

   task automatic run_msg(input logic [3:0] typ, input string tgt, input logic [31:0] seq,
                          input logic [31:0] beg, input logic [3:0] h, input bit stall,
                          input bit inject_busy);
      int base_incr, base_err, cycles;
      build_exp(typ, tgt, seq, beg);
      got_q.delete(); sop_q.delete(); eop_q.delete();
      host_bad = 0; base_incr = incr_cnt; base_err = err_cnt; cur_host = h;
      rand_ready = stall;
      @(posedge clk);
      #1 drive_req(typ, tgt, 4'(tgt.len()), seq, beg, h);
      initiate_msg = 1'b1;
      @(posedge clk);
      #1 initiate_msg = 1'b0;
      @(negedge clk);
      check_eq("busy_after_accept", 64'({busy, tx_valid}), 64'(2'b10));
      @(negedge clk);
      check_eq("valid_at_accept_plus_2", 64'({tx_valid, tx_sop, tx_data}), 64'({2'b11, 8'h38}));
      cycles = 0;
      while (incr_cnt == base_incr && cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (inject_busy && cycles == 4) initiate_msg = 1'b1;
         if (inject_busy && cycles == 5) initiate_msg = 1'b0;
      end
      rand_ready = 1'b0;
      check_eq("completed_in_time", 64'(cycles < 2000), 64'(1));
      check_eq("busy_low_at_incr", 64'(busy), 64'(0));
      check_eq("stream_len", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check_eq($sformatf("byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      check_eq("sop_once_at_0", 64'({sop_q.size(), (sop_q.size() > 0) ? sop_q[0] : -1}),
               64'({32'd1, 32'd0}));
      check_eq("eop_once_at_last", 64'({eop_q.size(), (eop_q.size() > 0) ? eop_q[0] : -1}),
               64'({32'd1, exp_q.size() - 1}));
      check_eq("host_stable", 64'(host_bad), 64'(0));
      check_eq("seq_incr_once", 64'(incr_cnt - base_incr), 64'(1));
      @(negedge clk);
      check_eq("seq_incr_single_cycle", 64'(incr_cnt - base_incr), 64'(1));
      check_eq("error_count", 64'(err_cnt - base_err), 64'(inject_busy));
   endtask

   task automatic req_illegal(input string tag, input logic [3:0] typ, input logic [3:0] n);
      int base_incr, base_err;
      got_q.delete(); base_incr = incr_cnt; base_err = err_cnt;
      @(posedge clk);
      #1 drive_req(typ, "ABCDEFGH", n, 32'h1, 32'h0, 4'd2);
      initiate_msg = 1'b1;
      @(posedge clk);
      #1 initiate_msg = 1'b0;
      repeat (6) @(negedge clk);
      check_eq({tag, "_error_pulse"}, 64'(err_cnt - base_err), 64'(1));
      check_eq({tag, "_no_bytes"}, 64'({got_q.size(), busy, 31'(incr_cnt - base_incr)}), 64'(0));
   endtask

   function automatic string rand_target(input int n);
      string s;
      s = "";
      for (int i = 0; i < n; i++) s = {s, string'(8'(8'h41 + 8'($urandom_range(0, 25))))};
      return s;
   endfunction

   function automatic logic [31:0] rand_bcd();
      logic [31:0] v;
      for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [3:0] types [4];
      int base_incr, cycles;
      types = '{MSG_LOGON, MSG_LOGOUT, MSG_HEARTBEAT, MSG_RESEND_REQ};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_outputs", 64'({tx_data, tx_valid, tx_sop, tx_eop, tx_host, busy, seq_incr, error}), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      run_msg(MSG_HEARTBEAT, "BRKR", 32'h00000007, 32'h0, 4'd3, 1'b0, 1'b0);
      check_eq("hb_bodylen", 64'(lll_got()), 64'("037"));
      run_msg(MSG_LOGON, "EXCH01", rand_bcd(), 32'h0, 4'd1, 1'b0, 1'b0);
      check_eq("logon_bodylen", 64'(lll_got()), 64'("051"));
      run_msg(MSG_RESEND_REQ, "BRKR", 32'h00000123, 32'h00000120, 4'd2, 1'b0, 1'b0);
      check_eq("resend_bodylen", 64'(lll_got()), 64'("053"));

      run_msg(MSG_LOGOUT, "VENUE7", 32'h00004521, 32'h0, 4'd0, 1'b0, 1'b0);
      ref_q = got_q;
      run_msg(MSG_LOGOUT, "VENUE7", 32'h00004521, 32'h0, 4'd0, 1'b1, 1'b0);
      check_eq("stall_same_len", 64'(got_q.size()), 64'(ref_q.size()));
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
         check_eq($sformatf("stall_same_byte%0d", i), 64'(got_q[i]), 64'(ref_q[i]));

      run_msg(MSG_HEARTBEAT, "Q", 32'h99999999, 32'h0, 4'd5, 1'b0, 1'b1);
      req_illegal("len_zero", MSG_HEARTBEAT, 4'd0);
      req_illegal("len_nine", MSG_LOGON, 4'd9);
      req_illegal("bad_type", 4'hF, 4'd4);
      run_msg(MSG_LOGON, "ABCDEFGH", 32'h12345678, 32'h0, 4'd7, 1'b1, 1'b0);

      // Abandon a logon mid-body with reset.
      got_q.delete(); eop_q.delete(); base_incr = incr_cnt;
      @(posedge clk);
      #1 drive_req(MSG_LOGON, "MIDRST", 4'd6, 32'h00000042, 32'h0, 4'd4);
      cur_host = 4'd4; initiate_msg = 1'b1;
      @(posedge clk);
      #1 initiate_msg = 1'b0;
      cycles = 0;
      while (got_q.size() < 30 && cycles < 500) begin
         @(negedge clk);
         cycles++;
      end
      check_eq("reached_mid_body", 64'(cycles < 500), 64'(1));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_reset_outputs", 64'({tx_data, tx_valid, tx_sop, tx_eop, tx_host, busy, seq_incr, error}), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("mid_reset_no_eop_no_incr", 64'({eop_q.size(), 32'(incr_cnt - base_incr)}), 64'(0));
      run_msg(MSG_HEARTBEAT, "BRKR", 32'h00000008, 32'h0, 4'd3, 1'b0, 1'b0);

      for (int k = 0; k < 10; k++)
         run_msg(types[$urandom_range(0, 3)], rand_target($urandom_range(1, 8)), rand_bcd(),
                 rand_bcd(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);

      check_eq("incr_never_while_busy", 64'(incr_busy_bad), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fix_msg_composer.md
Name: fix_msg_composer

Overview:
Transmit-side counterpart of the session manager. It accepts a one-cycle create request (message type, target host, TargetCompID value and size) and serialises a complete FIX 4.2 session message byte-by-byte to the TOE transmit path. The serialised message carries header, BodyLength, MsgSeqNum and CheckSum. The block raises busy while composing, so the session manager holds further requests, and it pulses the sequence generator once each message has been fully sent.

Parameters:
NUM_HOST, `HOST_ADDR_WIDTH, host index width
VALUE_WIDTH, `VALUE_DATA_WIDTH (64), TargetCompID value field; ASCII, left-aligned, first char in [VALUE_WIDTH-1 -: 8]
SIZE, `VALUE_SIZE (4), width of the TargetCompID character count
SENDER_ID, "FIXENG01" (64 bits), fixed 8-char SenderCompID

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
initiate_msg_i  in  1  create request strobe
create_message_i  in  4  `logon / `logout / `heartbeat / `resendReq
host_i  in  NUM_HOST  destination session
targetCompId_i  in  VALUE_WIDTH  TargetCompID chars
s_v_targetCompId_i  in  SIZE  TargetCompID length in chars
seq_bcd_i  in  32  outgoing MsgSeqNum, 8 BCD digits
begin_seq_bcd_i  in  32  BeginSeqNo for ResendRequest, 8 BCD digits
tx_ready_i  in  1  TOE accepts byte
tx_data_o  out  8  ASCII byte
tx_valid_o  out  1  byte valid
tx_sop_o  out  1  first byte of message
tx_eop_o  out  1  last byte of message
tx_host_o  out  NUM_HOST  session of current message
busy_o  out  1  composer occupied
seq_incr_o  out  1  one-cycle pulse to sequence generator
error_o  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; latched fields cleared. A message that was mid-stream is abandoned with no eop and no seq_incr.
- Accept: initiate_msg_i high in IDLE with a legal request. All inputs are latched that cycle, and busy_o goes high the next cycle.
- Requests arriving while busy_o=1 are ignored and raise error_o.
- Illegal requests are dropped, raise error_o and leave the block in IDLE:
  - create_message_i not one of the four defined codes;
  - s_v_targetCompId_i = 0;
  - s_v_targetCompId_i > VALUE_WIDTH/8.
- FSM states:
  - IDLE -> CALC on accept.
  - CALC: one cycle. BodyLength = 33 + N + extra, where N = target chars and extra = 12 for Logon, 16 for ResendRequest, 0 otherwise. Checksum accumulator is cleared.
  - CALC -> EMIT.
  - EMIT -> TRAIL after the body's final SOH.
  - TRAIL -> IDLE after the final SOH has been accepted.
- Latency: tx_valid_o rises 2 cycles after the accept edge.
- Byte stream (SOH=0x01, written |):
  - "8=FIX.4.2|9=LLL|35=T|49=<SENDER_ID>|56=<N chars>|34=<8 digits>|"
  - then the type-specific fields;
  - then "10=CCC|".
- Type char T: Logon 'A', Logout '5', Heartbeat '0', ResendRequest '2'.
- Type-specific fields:
  - Logon: "98=0|108=30|".
  - ResendRequest: "7=<begin 8 digits>|16=0|".
  - Logout and Heartbeat: none.
- LLL counts bytes from "35=" through the SOH before "10=". It is always 3 digits, zero-padded.
- Sequence numbers are always 8 digits, leading zeros kept; each BCD nibble n is emitted as 0x30+n.
- CheckSum: mod-256 sum of every byte from '8' through the SOH before "10=", emitted as 3 zero-padded decimal digits.
- Handshake:
  - A byte transfers when tx_valid_o & tx_ready_i.
  - While tx_ready_i=0, tx_data_o, sop, eop and tx_host_o hold stable.
  - tx_valid_o never drops mid-message.
  - sop coincides with '8'; eop coincides with the final SOH.
- Completion:
  - seq_incr_o pulses in the cycle after the eop transfer.
  - busy_o falls in that same cycle.
  - A new request is accepted the following cycle.
- tx_host_o equals the latched host for the whole message.

Decomposition:
- fix_pkg: message-type codes (shared with session manager), SOH, type-char map, body-length overhead constants (33, 12, 16), field tag strings.
- Sub-module fix_dec3: combinational 8-bit binary to 3 ASCII digits. It is instantiated twice, once for BodyLength and once for CheckSum.

Test Plan:
- Heartbeat, host 3, target "BRKR" (N=4), seq 0x00000007, tx_ready_i always 1 -> exact stream "8=FIX.4.2|9=037|35=0|49=FIXENG01|56=BRKR|34=00000007|10=CCC|". CCC matches the model's mod-256 sum; sop on byte 0; single seq_incr_o; tx_valid_o at accept+2.
- Logon, target "EXCH01" -> 9=051, "98=0|108=30|" before checksum; tx_host_o stable throughout.
- ResendRequest, begin_seq 0x00000120 -> 9=053 (4-char target) and "7=00000120|16=0|" present.
- Random tx_ready_i backpressure (50%) on a Logout -> byte sequence identical to the no-stall run; outputs held while stalled.
- Second initiate while busy, and a request with s_v_targetCompId_i=0 -> error_o pulses, no extra bytes, seq_incr_o count unchanged.
- rst asserted mid-body -> next cycle all outputs 0, no eop, no seq_incr; a subsequent Heartbeat is emitted correctly.
